// File: rtl/vscale_regfile_wr_arbiter.sv
// Shares the register file write port between the in-order writeback (priority) and a
// long-latency unit behind a small FIFO; also tracks registers still owed a late result.
module vscale_regfile_wr_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              wb_stall,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_wa,
  input  logic [DATA_W-1:0] lu_wd,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              hazard,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              proto_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ScW  = $clog2(STARVE_MAX + 1);
  localparam int unsigned NReg = 1 << ADDR_W;

  logic [ADDR_W-1:0] mem_wa_q [DEPTH];
  logic [DATA_W-1:0] mem_wd_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [ScW-1:0]    starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              perr_q;
  logic [NReg-1:0]   busy_q, busy_d;

  logic fifo_empty, fifo_full, accept;
  logic grant_wb, grant_head, grant_byp, push, pop, starve_inc;
  logic [ADDR_W-1:0] sec_wa;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(DEPTH));
  assign lu_ready   = !fifo_full;
  assign accept     = lu_valid && lu_ready;

  // Fixed priority: writeback, then FIFO head, then same-cycle bypass of an empty FIFO.
  assign grant_wb   = !stall_q && wb_wen;
  assign grant_head = !grant_wb && !fifo_empty;
  assign grant_byp  = !grant_wb && fifo_empty && accept;
  assign push       = accept && !grant_byp;
  assign pop        = grant_head;
  assign starve_inc = !fifo_empty && grant_wb;
  assign sec_wa     = grant_head ? mem_wa_q[rd_ptr_q] : lu_wa;

  always_comb begin
    rf_wen = 1'b0;
    rf_wa  = '0;
    rf_wd  = '0;
    if (grant_wb) begin
      rf_wen = 1'b1;
      rf_wa  = wb_wa;
      rf_wd  = wb_wd;
    end else if (grant_head) begin
      rf_wen = 1'b1;
      rf_wa  = mem_wa_q[rd_ptr_q];
      rf_wd  = mem_wd_q[rd_ptr_q];
    end else if (grant_byp) begin
      rf_wen = 1'b1;
      rf_wa  = lu_wa;
      rf_wd  = lu_wd;
    end
  end

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_inc && (starve_q != ScW'(STARVE_MAX))) begin
      starve_d = starve_q + ScW'(1);
    end else begin
      starve_d = starve_q;
    end
    // Stall once the head has lost STARVE_MAX arbitrations; hold until the FIFO drains.
    stall_d = (starve_inc && (starve_q == ScW'(STARVE_MAX - 1))) ||
              (stall_q && (count_d != '0));
  end

  // Clear before set so a same-cycle reissue of the register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (grant_head || grant_byp) begin
      busy_d[sec_wa] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign hazard    = busy_q[ra1] || busy_q[ra2];
  assign wb_stall  = stall_q;
  assign proto_err = perr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      perr_q   <= 1'b0;
      busy_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      perr_q   <= perr_q || (wb_wen && stall_q);
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa_q[wr_ptr_q] <= lu_wa;
      mem_wd_q[wr_ptr_q] <= lu_wd;
    end
  end

endmodule

// File: tb/tb_vscale_regfile_wr_arbiter.sv
// Randomised bench for vscale_regfile_wr_arbiter: queue-based reference model, port writes
// checked by a separate monitor against an expected-write scoreboard.
module tb_vscale_regfile_wr_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_wen = 1'b0, lu_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0]  wb_wa = '0, lu_wa = '0, iss_rd = '0, ra1 = '0, ra2 = '0;
  logic [31:0] wb_wd = '0, lu_wd = '0;
  logic        wb_stall, lu_ready, hazard, rf_wen, proto_err;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  vscale_regfile_wr_arbiter #(
    .ADDR_W(5), .DATA_W(32), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_wen(wb_wen), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .ra1(ra1), .ra2(ra2), .hazard(hazard),
    .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t mq[$];    // model of pending secondary writes, oldest first
  wr_t expq[$];  // expected port writes, consumed by the monitor
  int  starve;
  bit  mstall, mperr;
  bit  mbusy[32];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rf_wen) begin
      wr_t e;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL port_write at %0t: got wa=%0d wd=%0h expected no write", $time,
                 rf_wa, rf_wd);
      end else begin
        e = expq.pop_front();
        if (rf_wa !== e.wa || rf_wd !== e.wd) begin
          errors++;
          $display("FAIL port_write at %0t: got wa=%0d wd=%0h expected wa=%0d wd=%0h",
                   $time, rf_wa, rf_wd, e.wa, e.wd);
        end
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    expq.delete();
    starve = 0;
    mstall = 0;
    mperr  = 0;
    foreach (mbusy[i]) mbusy[i] = 0;
  endtask

  // Called at posedge+1: apply inputs, predict this cycle, check, advance model state.
  task automatic cyc(input bit wen, input logic [4:0] wa, input logic [31:0] wd,
                     input bit lv, input logic [4:0] lwa, input logic [31:0] lwd,
                     input bit iv, input logic [4:0] ird,
                     input logic [4:0] r1, input logic [4:0] r2);
    bit rdy, hz, acc, ew, popd, byp, ginc, was_empty, nstall;
    int st_old;
    wr_t w;
    wb_wen = wen; wb_wa = wa; wb_wd = wd;
    lu_valid = lv; lu_wa = lwa; lu_wd = lwd;
    iss_valid = iv; iss_rd = ird; ra1 = r1; ra2 = r2;
    rdy = mq.size() < DEPTH;
    hz  = mbusy[r1] || mbusy[r2];
    acc = lv && rdy;
    ew = 0; popd = 0; byp = 0;
    was_empty = (mq.size() == 0);
    st_old = starve;
    if (!mstall && wen) begin
      ew = 1; w.wa = wa; w.wd = wd;
    end else if (!was_empty) begin
      ew = 1; w = mq.pop_front(); popd = 1; mbusy[w.wa] = 0;
    end else if (acc) begin
      ew = 1; w.wa = lwa; w.wd = lwd; byp = 1; mbusy[lwa] = 0;
    end
    if (ew) expq.push_back(w);
    if (acc && !byp) begin
      wr_t n;
      n.wa = lwa; n.wd = lwd;
      mq.push_back(n);
    end
    #3;
    chk("lu_ready", 32'(lu_ready), 32'(rdy));
    chk("hazard", 32'(hazard), 32'(hz));
    chk("wb_stall", 32'(wb_stall), 32'(mstall));
    chk("proto_err", 32'(proto_err), 32'(mperr));
    chk("rf_wen", 32'(rf_wen), 32'(ew));
    ginc = !was_empty && !mstall && wen;
    if (was_empty || popd) starve = 0;
    else if (ginc && starve < STARVE_MAX) starve++;
    nstall = (ginc && st_old == STARVE_MAX - 1) || (mstall && mq.size() != 0);
    if (iv && ird != 0) mbusy[ird] = 1;
    mbusy[0] = 0;
    if (wen && mstall) mperr = 1;
    mstall = nstall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] r1);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    reset = 1'b1;
    wb_wen = 0; lu_valid = 0; iss_valid = 0;
    #1;
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_wb_stall", 32'(wb_stall), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Bypass into an empty FIFO.
    cyc(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    // Writeback priority with two queued secondary writes.
    cyc(1, 3, 32'h33, 1, 7, 32'h77, 0, 0, 0, 0);
    cyc(1, 3, 32'h34, 1, 8, 32'h88, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0);
    idle(3, 0);

    // Starvation: one queued entry, writeback held until it stalls.
    cyc(1, 3, 32'h1, 1, 7, 32'h70, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 3, 32'h2 + i, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    do_reset();

    // Scoreboard: hazard on r10 until its late write lands; x0 never busy.
    cyc(0, 0, 0, 0, 0, 0, 1, 10, 10, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 10, 0);
    idle(2, 10);
    cyc(0, 0, 0, 1, 10, 32'hA, 0, 0, 10, 0);
    idle(1, 10);
    // Same-cycle set and clear of r12.
    cyc(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
    cyc(0, 0, 0, 1, 12, 32'hC, 1, 12, 12, 0);
    idle(2, 12);
    do_reset();

    // Reset mid-burst with the FIFO full and a register busy.
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    cyc(1, 3, 32'h5, 1, 7, 32'h7, 0, 0, 9, 0);
    cyc(1, 3, 32'h6, 1, 8, 32'h8, 0, 0, 9, 0);
    do_reset();

    // Randomised traffic, narrow register range for collisions, rare protocol errors.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 400; i++) begin
        bit wen;
        wen = mstall ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 55);
        cyc(wen, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 25, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(4, 0);
      chk("expq_drained", 32'(expq.size()), 32'd0);
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
